// File: rtl/bcd_accum_ctrl_pkg.sv
// Shared types for the BCD accumulator display path.
// Digit type, key FSM states and operand saturation.
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      RELEASED,
      WAIT_PRESS,
      PRESSED,
      WAIT_RELEASE
   } key_state_t;

   function automatic bcd_t sat_op(input logic [3:0] sw);
      return (sw > BCD_MAX) ? BCD_MAX : sw;
   endfunction

endpackage

// File: rtl/bcd_accum_ctrl_if.sv
// Key, operand and digit bus between the board
// and the BCD accumulator.
interface bcd_accum_ctrl_if;
   import bcd_pkg::*;

   logic key_add_n;
   logic key_sub_n;
   logic key_clr_n;
   logic [3:0] sw;
   bcd_t seg_data_1;
   bcd_t seg_data_2;
   logic carry;
   logic borrow;

   modport master (
      output key_add_n, key_sub_n, key_clr_n, sw,
      input  seg_data_1, seg_data_2, carry, borrow
   );

   modport slave (
      input  key_add_n, key_sub_n, key_clr_n, sw,
      output seg_data_1, seg_data_2, carry, borrow
   );

endinterface

// File: rtl/bcd_accum_ctrl_key_debounce.sv
// Synchronizer plus debounce FSM for one active-low key.
// Emits a single-cycle pulse per accepted press.
module key_debounce
   import bcd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0] sync_q, sync_d;
   key_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic synced;

   // Sync flops idle high so a key held through reset is re-qualified.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign synced = sync_q[1];

   always_comb begin
      sync_d      = {sync_q[0], key_n};
      state_d     = state_q;
      cnt_d       = cnt_q;
      press_pulse = 1'b0;
      unique case (state_q)
         RELEASED: begin
            if (!synced) begin
               state_d = WAIT_PRESS;
               cnt_d   = '0;
            end
         end
         WAIT_PRESS: begin
            if (synced) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = PRESSED;
               press_pulse = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSED: begin
            if (synced) begin
               state_d = WAIT_RELEASE;
               cnt_d   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (!synced) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = RELEASED;
      endcase
   end

endmodule

// File: rtl/bcd_accum_ctrl.sv
// Two-digit BCD add/subtract accumulator driven by three
// debounced keys; feeds the seven-segment decoder.
module bcd_accum_ctrl
   import bcd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input logic clk,
   input logic rst,
   bcd_accum_ctrl_if.slave bus
);

   logic add_p, sub_p, clr_p;
   bcd_t tens_q, tens_d;
   bcd_t units_q, units_d;
   logic carry_q, carry_d;
   logic borrow_q, borrow_d;
   logic [4:0] op5, sum5;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
      .clk(clk), .rst(rst), .key_n(bus.key_add_n), .press_pulse(add_p)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
      .clk(clk), .rst(rst), .key_n(bus.key_sub_n), .press_pulse(sub_p)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .clk(clk), .rst(rst), .key_n(bus.key_clr_n), .press_pulse(clr_p)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens_q   <= '0;
         units_q  <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         tens_q   <= tens_d;
         units_q  <= units_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
      end
   end

   always_comb begin
      tens_d   = tens_q;
      units_d  = units_q;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      op5      = {1'b0, sat_op(bus.sw)};
      sum5     = {1'b0, units_q} + op5;
      // Clear dominates; simultaneous add and sub cancel out.
      if (clr_p) begin
         tens_d  = '0;
         units_d = '0;
      end else if (add_p && !sub_p) begin
         if (sum5 > 5'd9) begin
            units_d = bcd_t'(sum5 - 5'd10);
            if (tens_q == BCD_MAX) begin
               tens_d  = '0;
               carry_d = 1'b1;
            end else begin
               tens_d = tens_q + 4'd1;
            end
         end else begin
            units_d = bcd_t'(sum5);
         end
      end else if (sub_p && !add_p) begin
         if ({1'b0, units_q} >= op5) begin
            units_d = bcd_t'({1'b0, units_q} - op5);
         end else begin
            units_d = bcd_t'({1'b0, units_q} + 5'd10 - op5);
            if (tens_q == '0) begin
               tens_d   = BCD_MAX;
               borrow_d = 1'b1;
            end else begin
               tens_d = tens_q - 4'd1;
            end
         end
      end
   end

   assign bus.seg_data_1 = tens_q;
   assign bus.seg_data_2 = units_q;
   assign bus.carry      = carry_q;
   assign bus.borrow     = borrow_q;

endmodule

// File: tb/tb_bcd_accum_ctrl.sv
// Self-checking bench for bcd_accum_ctrl: directed scenarios
// followed by random key/operand traffic against a 0..99 model.
module tb_bcd_accum_ctrl;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   int acc = 0;

   always #5 clk = ~clk;

   bcd_accum_ctrl_if bus_if ();

   bcd_accum_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   function automatic logic [7:0] digits(input int v);
      logic [7:0] d;
      d[7:4] = 4'(v / 10);
      d[3:0] = 4'(v % 10);
      return d;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_digits(input string tag, input int v);
      chk(tag, {bus_if.seg_data_1, bus_if.seg_data_2}, digits(v));
   endtask

   task automatic chk_flags(input string tag, input logic c,
                            input logic b);
      chk(tag, {6'd0, bus_if.carry, bus_if.borrow}, {6'd0, c, b});
   endtask

   // Reference: the display shows a number 0..99 that wraps modulo 100.
   task automatic model_apply(input logic a, input logic s, input logic c,
                              output logic ec, output logic eb);
      int op;
      op = (int'(bus_if.sw) > 9) ? 9 : int'(bus_if.sw);
      ec = 1'b0;
      eb = 1'b0;
      if (c) begin
         acc = 0;
      end else if (a && !s) begin
         acc = acc + op;
         if (acc > 99) begin
            acc = acc - 100;
            ec = 1'b1;
         end
      end else if (s && !a) begin
         acc = acc - op;
         if (acc < 0) begin
            acc = acc + 100;
            eb = 1'b1;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic a, input logic s,
                        input logic c, input int hold);
      logic ec, eb;
      int prev;
      prev = acc;
      @(negedge clk);
      bus_if.key_add_n = !a;
      bus_if.key_sub_n = !s;
      bus_if.key_clr_n = !c;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk_digits({tag, "_pre"}, prev);
      model_apply(a, s, c, ec, eb);
      @(negedge clk);
      chk_digits({tag, "_upd"}, acc);
      chk_flags({tag, "_flag"}, ec, eb);
      @(negedge clk);
      chk_flags({tag, "_flag_end"}, 1'b0, 1'b0);
      repeat (hold - 2) @(negedge clk);
      chk_digits({tag, "_hold"}, acc);
      bus_if.key_add_n = 1'b1;
      bus_if.key_sub_n = 1'b1;
      bus_if.key_clr_n = 1'b1;
      repeat (14) @(negedge clk);
      chk_digits({tag, "_rel"}, acc);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      bus_if.key_add_n = 1'b1;
      bus_if.key_sub_n = 1'b1;
      bus_if.key_clr_n = 1'b1;
      bus_if.sw = 4'd0;
      repeat (3) @(negedge clk);
      chk_digits("rst_digits", 0);
      chk_flags("rst_flags", 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk({"idle"}, {bus_if.seg_data_1, bus_if.seg_data_2,
                        bus_if.carry, bus_if.borrow, 6'd0}, 16'd0);
      end

      bus_if.sw = 4'd7;
      do_op("add7_a", 1'b1, 1'b0, 1'b0, 20);
      do_op("add7_b", 1'b1, 1'b0, 1'b0, 20);
      bus_if.sw = 4'd5;
      do_op("add5", 1'b1, 1'b0, 1'b0, 20);
      chk_digits("at_19", 19);

      do_op("clr", 1'b0, 1'b0, 1'b1, 8);
      bus_if.sw = 4'd9;
      for (int i = 0; i < 10; i++) do_op("fill9", 1'b1, 1'b0, 1'b0, 4);
      bus_if.sw = 4'd8;
      do_op("fill8", 1'b1, 1'b0, 1'b0, 4);
      chk_digits("at_98", 98);
      bus_if.sw = 4'd5;
      do_op("carry", 1'b1, 1'b0, 1'b0, 8);
      chk_digits("at_03", 3);
      bus_if.sw = 4'd4;
      do_op("borrow", 1'b0, 1'b1, 1'b0, 8);
      chk_digits("at_99", 99);

      do_op("clr2", 1'b0, 1'b0, 1'b1, 8);
      bus_if.sw = 4'd12;
      do_op("sat", 1'b1, 1'b0, 1'b0, 8);
      chk_digits("at_09", 9);

      @(negedge clk);
      bus_if.key_add_n = 1'b0;
      repeat (3) @(negedge clk);
      bus_if.key_add_n = 1'b1;
      repeat (20) @(negedge clk);
      chk_digits("glitch", acc);
      chk_flags("glitch_flags", 1'b0, 1'b0);

      bus_if.sw = 4'd3;
      do_op("add_sub", 1'b1, 1'b1, 1'b0, 8);
      chk_digits("add_sub_09", 9);
      do_op("add_clr", 1'b1, 1'b0, 1'b1, 8);

      bus_if.sw = 4'd6;
      do_op("pre_rst", 1'b1, 1'b0, 1'b0, 8);
      @(negedge clk);
      bus_if.key_add_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      acc = 0;
      #1;
      chk_digits("async_rst", acc);
      chk_flags("async_rst_flags", 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk_digits("requal_pre", acc);
      begin
         logic ec, eb;
         model_apply(1'b1, 1'b0, 1'b0, ec, eb);
         @(negedge clk);
         chk_digits("requal_upd", acc);
         chk_flags("requal_flags", ec, eb);
      end
      repeat (10) @(negedge clk);
      chk_digits("requal_once", acc);
      bus_if.key_add_n = 1'b1;
      repeat (14) @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         bus_if.sw = 4'($urandom_range(0, 15));
         k = int'($urandom_range(0, 9));
         if (k < 4)       do_op("rnd_add", 1'b1, 1'b0, 1'b0, 6);
         else if (k < 8)  do_op("rnd_sub", 1'b0, 1'b1, 1'b0, 6);
         else if (k == 8) do_op("rnd_clr", 1'b0, 1'b0, 1'b1, 6);
         else             do_op("rnd_both", 1'b1, 1'b1, 1'b0, 6);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
